// File: rtl/prio_queue_pkg.sv
// Shared widths for the PHOLD event scheduler queue, plus the cell next-state selector encoding.
package prio_queue_pkg;

    localparam int TW          = 16;
    localparam int LP_LSB      = TW;
    localparam int LP_WID      = 3;
    localparam int DW          = TW + LP_WID;
    localparam int QUEUE_DEPTH = 16;
    localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_PREV,
        SEL_NEXT,
        SEL_INP
    } cell_sel_e;

endpackage

// File: rtl/prio_queue_if.sv
// Enqueue/dequeue handshake and status bundle of the event priority queue.
interface prio_queue_if #(
    parameter int DW    = prio_queue_pkg::DW,
    parameter int CNT_W = prio_queue_pkg::CNT_W
);

    logic             enq;
    logic             deq;
    logic [DW-1:0]    inp_data;
    logic [DW-1:0]    out_data;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] elem_cnt;

    modport master (
        output enq, deq, inp_data,
        input  out_data, full, empty, elem_cnt
    );

    modport slave (
        input  enq, deq, inp_data,
        output out_data, full, empty, elem_cnt
    );

endinterface

// File: rtl/prio_queue_cell.sv
// One slot of the sorted systolic array: holds, shifts down, shifts up or captures the new entry.
module prio_queue_cell #(
    parameter int DW      = prio_queue_pkg::DW,
    parameter int CMP_WID = prio_queue_pkg::TW,
    parameter bit IS_HEAD = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          do_enq,
    input  logic          do_deq,
    input  logic [DW-1:0] inp_data,
    input  logic          ins_above,
    input  logic          ins_below,
    input  logic          prev_valid,
    input  logic [DW-1:0] prev_data,
    input  logic          next_valid,
    input  logic [DW-1:0] next_data,
    output logic          ins,
    output logic          valid,
    output logic [DW-1:0] data
);
    import prio_queue_pkg::*;

    cell_sel_e sel;

    // The new entry belongs at or before this slot; strict compare keeps equal keys FIFO.
    assign ins = !valid || (inp_data[CMP_WID-1:0] < data[CMP_WID-1:0]);

    always_comb begin
        // NOTE: sel gets its default before the case so no path leaves it unassigned (no latch).
        sel = SEL_HOLD;
        case ({do_enq, do_deq})
            2'b10: if (ins) sel = ins_above ? SEL_PREV : SEL_INP;
            2'b01: sel = SEL_NEXT;
            // Head leaves, so position is judged against the entry that would move up into us.
            2'b11: begin
                if (!ins_below)
                    sel = SEL_NEXT;
                else if (IS_HEAD || !ins)
                    sel = SEL_INP;
            end
            default: sel = SEL_HOLD;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all slots shift from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: slot data is cleared on reset too, so invalid slots always read as zero.
            valid <= 1'b0;
            data  <= '0;
        end else begin
            case (sel)
                SEL_PREV: begin
                    valid <= prev_valid;
                    data  <= prev_data;
                end
                SEL_NEXT: begin
                    valid <= next_valid;
                    data  <= next_data;
                end
                SEL_INP: begin
                    valid <= 1'b1;
                    data  <= inp_data;
                end
                default: begin
                    valid <= valid;
                    data  <= data;
                end
            endcase
        end
    end

endmodule

// File: rtl/prio_queue.sv
// Fixed-depth min-priority event queue: sorted shift-register array with show-ahead head output.
module prio_queue #(
    parameter int CMP_WID = prio_queue_pkg::TW,
    parameter int DW      = prio_queue_pkg::DW,
    parameter int DEPTH   = prio_queue_pkg::QUEUE_DEPTH,
    parameter int CNT_W   = prio_queue_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    prio_queue_if.slave  q
);

    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             do_enq;
    logic             do_deq;

    // Index i+1 is slot i; index 0 and DEPTH+1 are the constant boundaries above/below the array.
    logic [DEPTH+1:0] ins_x;
    logic [DEPTH+1:0] valid_x;
    logic [DW-1:0]    data_x [DEPTH+2];

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // A dequeue frees a slot, so a simultaneous insert is accepted even when full.
    assign do_deq = q.deq && !empty;
    assign do_enq = q.enq && (!full || do_deq);

    assign ins_x[0]          = 1'b0;
    assign ins_x[DEPTH+1]    = 1'b1;
    assign valid_x[0]        = 1'b0;
    assign valid_x[DEPTH+1]  = 1'b0;
    assign data_x[0]         = '0;
    assign data_x[DEPTH+1]   = '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        prio_queue_cell #(
            .DW      (DW),
            .CMP_WID (CMP_WID),
            .IS_HEAD (i == 0)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .do_enq     (do_enq),
            .do_deq     (do_deq),
            .inp_data   (q.inp_data),
            .ins_above  (ins_x[i]),
            .ins_below  (ins_x[i+2]),
            .prev_valid (valid_x[i]),
            .prev_data  (data_x[i]),
            .next_valid (valid_x[i+2]),
            .next_data  (data_x[i+2]),
            .ins        (ins_x[i+1]),
            .valid      (valid_x[i+1]),
            .data       (data_x[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (do_enq && !do_deq)
            cnt <= cnt + CNT_W'(1);
        else if (do_deq && !do_enq)
            cnt <= cnt - CNT_W'(1);
    end

    assign q.out_data = valid_x[1] ? data_x[1] : '0;
    assign q.full     = full;
    assign q.empty    = empty;
    assign q.elem_cnt = cnt;

endmodule

// File: tb/tb_prio_queue.sv
// Directed bench for prio_queue: ordering, FIFO ties, full/empty boundaries and reset override.
module tb_prio_queue;
    import prio_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    prio_queue_if #(.DW(DW), .CNT_W(CNT_W)) q ();

    prio_queue #(
        .CMP_WID (TW),
        .DW      (DW),
        .DEPTH   (QUEUE_DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int p, input int k);
        logic [31:0] pv;
        logic [31:0] kv;
        pv = p;
        kv = k;
        return {pv[LP_WID-1:0], kv[TW-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of enq/deq, then leave time for the new state to settle before sampling.
    task automatic step(input logic e, input logic d, input logic [DW-1:0] x);
        q.enq      = e;
        q.deq      = d;
        q.inp_data = x;
        @(posedge clk);
        #1;
        q.enq = 1'b0;
        q.deq = 1'b0;
    endtask

    logic [DW-1:0] exp_q [$];

    initial begin
        reset      = 1'b1;
        q.enq      = 1'b0;
        q.deq      = 1'b0;
        q.inp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_cnt",   32'(q.elem_cnt), 0);
        check("rst_empty", 32'(q.empty),    1);
        check("rst_full",  32'(q.full),     0);
        check("rst_out",   32'(q.out_data), 0);
        step(1'b0, 1'b0, '0);
        check("idle_cnt",  32'(q.elem_cnt), 0);

        // Keys 5,2,9,2 with payloads 1,2,3,4: equal keys drain in arrival order.
        step(1'b1, 1'b0, mk(1, 5));
        step(1'b1, 1'b0, mk(2, 2));
        step(1'b1, 1'b0, mk(3, 9));
        step(1'b1, 1'b0, mk(4, 2));
        check("four_cnt", 32'(q.elem_cnt), 4);
        exp_q = '{mk(2, 2), mk(4, 2), mk(1, 5), mk(3, 9)};
        foreach (exp_q[i]) begin
            check($sformatf("small_deq%0d", i), 32'(q.out_data), 32'(exp_q[i]));
            step(1'b0, 1'b1, '0);
        end
        check("small_empty", 32'(q.empty), 1);
        check("small_out0",  32'(q.out_data), 0);

        // Fill with descending keys 15..0, payload = fill index mod 8.
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, mk(i % 8, 15 - i));
        check("fill_full", 32'(q.full),     1);
        check("fill_cnt",  32'(q.elem_cnt), 16);
        check("fill_head", 32'(q.out_data), 32'(mk(7, 0)));

        step(1'b1, 1'b0, mk(2, 7));
        check("full_enq_cnt",  32'(q.elem_cnt), 16);
        check("full_enq_head", 32'(q.out_data), 32'(mk(7, 0)));

        // Replace the head with key 3 (payload 5) while full.
        step(1'b1, 1'b1, mk(5, 3));
        check("swap_cnt",  32'(q.elem_cnt), 16);
        check("swap_full", 32'(q.full),     1);
        check("swap_head", 32'(q.out_data), 32'(mk(6, 1)));

        exp_q = {};
        for (int k = 1; k < 16; k++) begin
            exp_q.push_back(mk((15 - k) % 8, k));
            if (k == 3)
                exp_q.push_back(mk(5, 3));
        end
        foreach (exp_q[i]) begin
            check($sformatf("drain%0d", i), 32'(q.out_data), 32'(exp_q[i]));
            step(1'b0, 1'b1, '0);
        end
        check("drain_empty", 32'(q.empty),    1);
        check("drain_cnt",   32'(q.elem_cnt), 0);

        // Dequeue of an empty queue is ignored; with enq it becomes a plain insert.
        step(1'b0, 1'b1, '0);
        check("empty_deq_cnt", 32'(q.elem_cnt), 0);
        check("empty_deq_emp", 32'(q.empty),    1);
        step(1'b1, 1'b1, mk(6, 8));
        check("empty_both_cnt", 32'(q.elem_cnt), 1);
        check("empty_both_out", 32'(q.out_data), 32'(mk(6, 8)));

        // Reset overrides an enqueue in the same cycle.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, mk(i, 20 + i));
        check("pre_rst_cnt", 32'(q.elem_cnt), 5);
        reset      = 1'b1;
        q.enq      = 1'b1;
        q.inp_data = mk(1, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.enq = 1'b0;
        check("mid_rst_cnt",   32'(q.elem_cnt), 0);
        check("mid_rst_out",   32'(q.out_data), 0);
        check("mid_rst_empty", 32'(q.empty),    1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
